battle_board: RTL and testbench
===============================

# battle_board

Parametrised two-board battleship state store with placement, shot resolution, result marking, game-phase control and a pipelined cell readout for the renderer. Sits between the mouse/UART protocol logic and the board-drawing pipeline: it holds the own (host) fleet and the record of shots fired at the opponent (guest), and answers incoming enemy shots. Supersedes the fixed 10×10 board with explicit handshakes, bounds checking, a game-over flag and a re-arm (new game) sweep.

## Interface
Parameters:
- BOARD_W, 10, columns per board (2..15)
- BOARD_H, 10, rows per board (2..15)
- MAX_SHIPS, 10, ship cells to place before battle can start (1..BOARD_W*BOARD_H)
- CW, 4, coordinate width in bits (must cover max(BOARD_W, BOARD_H)-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- place_req  in  1  one-cycle pulse: put a ship cell on host board at (place_x, place_y)
- place_x, place_y  in  CW each  placement coordinate
- place_done  out  1  one-cycle pulse, one cycle after place_req
- place_ok  out  1  valid with place_done: 1 = cell written
- start_req  in  1  pulse: leave placement, enter battle
- shot_req  in  1  pulse: enemy shot at host (shot_x, shot_y)
- shot_x, shot_y  in  CW each  enemy shot coordinate
- shot_done  out  1  one-cycle pulse, one cycle after shot_req
- shot_result  out  2  valid with shot_done: 2'b10 hit, 2'b11 miss, 2'b00 rejected/repeat
- mark_req  in  1  pulse: record result of own shot on guest board
- mark_x, mark_y  in  CW each  guest coordinate
- mark_code  in  2  2'b10 hit or 2'b11 miss; 2'b00/2'b01 ignored
- new_game  in  1  pulse: accepted only in OVER; clears both boards
- rd_host_x, rd_host_y, rd_guest_x, rd_guest_y  in  CW each  renderer read addresses
- host_code, guest_code  out  2 each  cell codes, 1-cycle read latency
- ship_count  out  $clog2(MAX_SHIPS+1)  ship cells placed
- hits_taken  out  $clog2(MAX_SHIPS+1)  host ship cells hit
- phase  out  2  0 PLACE, 1 BATTLE, 2 OVER, 3 CLEAR
- fleet_sunk  out  1  high while hits_taken == MAX_SHIPS

## Operation
- Cell codes: 00 EMPTY, 01 SHIP, 10 HIT, 11 MISS.
- PLACE: place_req with in-range coord and host cell EMPTY and ship_count < MAX_SHIPS → cell := SHIP, ship_count+1, place_ok=1; otherwise place_ok=0, no write. start_req accepted only when ship_count == MAX_SHIPS → BATTLE; else ignored. shot_req/mark_req ignored (shot_done still pulses with 00).
- BATTLE: shot_req in range: EMPTY → MISS, result 11; SHIP → HIT, result 10, hits_taken+1; HIT/MISS or out of range → 00, no write. mark_req in range with code 10/11 → guest cell := mark_code (overwrite allowed); else ignored. When hits_taken reaches MAX_SHIPS → OVER on the following cycle.
- OVER: boards frozen; all requests except new_game ignored (done pulses still issued with ok=0 / result 00).
- CLEAR: row counter 0..BOARD_H-1 zeroes one row of both boards per cycle; counters zeroed on entry; then PLACE. Requests ignored.
- place_req/start_req ignored outside PLACE; new_game ignored outside OVER.
- Shot and mark in the same cycle: both processed (independent boards). Place and start same cycle: placement first, start evaluated on pre-update count.
- Out-of-range read address returns 00.

## Timing
- Reset: all cells 00, phase PLACE, ship_count 0, hits_taken 0, all done pulses 0, place_ok 0, shot_result 00, host_code/guest_code 00, fleet_sunk 0.
- Reset wins over every request in the same cycle; mid-CLEAR reset ends sweep immediately.
- Request → done: exactly 1 cycle; board/counter updates visible to readout 1 cycle after done (read latency 1).
- CLEAR lasts exactly BOARD_H cycles.
- Back-to-back requests every cycle supported; no busy signal.

## Structure
- Package battle_pkg: cell_t enum (EMPTY/SHIP/HIT/MISS), shot-result constants, phase_t enum.
- Sub-module board_bank: one BOARD_H×BOARD_W array of cell_t, one write port, one read-modify port, one registered read port, row-clear input; instantiated twice (host, guest). FSM and counters in battle_board.

## Test plan
- Reset, place (0,0) twice → first place_ok=1, second place_ok=0; ship_count=1; host_code at (0,0) = 01 one cycle after done.
- MAX_SHIPS=2: place 2 cells, third place_ok=0; start_req with count 1 ignored, with count 2 → phase=1.
- BATTLE: shot at ship → result 10, hits_taken=1; same cell again → 00; empty cell → 11, cell becomes 11; shot_x=BOARD_W → 00.
- Sink all ship cells → fleet_sunk=1, phase=2 next cycle; further shot_req → result 00, no change.
- Same-cycle shot_req and mark_req(3,4,10) → both applied; guest_code(3,4)=10.
- new_game in OVER → phase=3 for BOARD_H cycles then 0; all cells 00, counters 0; rst asserted mid-sweep → phase=0 next cycle.

Source files
------------

// File: rtl/battle_pkg.sv
// battle_pkg: shared cell, shot-result and phase types for the battleship board store
package battle_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, SHIP = 2'b01, HIT = 2'b10, MISS = 2'b11} cell_t;
  typedef enum logic [1:0] {PLACE = 2'd0, BATTLE = 2'd1, OVER = 2'd2, CLEAR = 2'd3} phase_t;
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_MISS = 2'b11;
  function automatic logic in_bounds(input int x, input int y, input int w, input int h);
    return x < w && y < h;
  endfunction
endpackage

// File: rtl/board_bank.sv
// board_bank: one board of cells with a write port, combinational probe port, registered read port and row clear
module board_bank
  import battle_pkg::*;
#(
  parameter int W  = 10,
  parameter int H  = 10,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_x,
  input  logic [CW-1:0] wr_y,
  input  cell_t         wr_data,
  input  logic [CW-1:0] rm_x,
  input  logic [CW-1:0] rm_y,
  output cell_t         rm_code,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  output cell_t         rd_code,
  input  logic          clr_en,
  input  logic [CW-1:0] clr_row
);
  cell_t cells [H][W];
  always_comb rm_code = in_bounds(int'(rm_x), int'(rm_y), W, H) ? cells[rm_y][rm_x] : EMPTY;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          cells[r][c] <= EMPTY;
      rd_code <= EMPTY;
    end else begin
      if (clr_en)
        for (int c = 0; c < W; c++)
          cells[clr_row][c] <= EMPTY;
      else if (wr_en)
        cells[wr_y][wr_x] <= wr_data;
      rd_code <= in_bounds(int'(rd_x), int'(rd_y), W, H) ? cells[rd_y][rd_x] : EMPTY;
    end
  end
endmodule

// File: rtl/battle_board.sv
// battle_board: two-board battleship store with placement, shot resolution, marking and phase control
module battle_board
  import battle_pkg::*;
#(
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 10,
  parameter int MAX_SHIPS = 10,
  parameter int CW        = 4,
  localparam int NW       = $clog2(MAX_SHIPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          place_req,
  input  logic [CW-1:0] place_x,
  input  logic [CW-1:0] place_y,
  output logic          place_done,
  output logic          place_ok,
  input  logic          start_req,
  input  logic          shot_req,
  input  logic [CW-1:0] shot_x,
  input  logic [CW-1:0] shot_y,
  output logic          shot_done,
  output logic [1:0]    shot_result,
  input  logic          mark_req,
  input  logic [CW-1:0] mark_x,
  input  logic [CW-1:0] mark_y,
  input  logic [1:0]    mark_code,
  input  logic          new_game,
  input  logic [CW-1:0] rd_host_x,
  input  logic [CW-1:0] rd_host_y,
  input  logic [CW-1:0] rd_guest_x,
  input  logic [CW-1:0] rd_guest_y,
  output logic [1:0]    host_code,
  output logic [1:0]    guest_code,
  output logic [NW-1:0] ship_count,
  output logic [NW-1:0] hits_taken,
  output logic [1:0]    phase,
  output logic          fleet_sunk
);
  localparam logic [NW-1:0] MAX_CNT = NW'(MAX_SHIPS);
  localparam logic [CW-1:0] LAST_ROW = CW'(BOARD_H - 1);
  phase_t phase_q, phase_d;
  logic [CW-1:0] clr_row;
  logic [CW-1:0] h_x, h_y;
  cell_t host_rm, guest_rm, host_rd, guest_rd, h_data;
  logic place_go, shot_go, mark_go, start_go, clr_en;
  always_comb begin
    h_x      = phase_q == PLACE ? place_x : shot_x;
    h_y      = phase_q == PLACE ? place_y : shot_y;
    place_go = phase_q == PLACE && place_req && in_bounds(int'(place_x), int'(place_y), BOARD_W, BOARD_H)
               && host_rm == EMPTY && ship_count < MAX_CNT;
    shot_go  = phase_q == BATTLE && shot_req && in_bounds(int'(shot_x), int'(shot_y), BOARD_W, BOARD_H)
               && (host_rm == EMPTY || host_rm == SHIP);
    mark_go  = phase_q == BATTLE && mark_req && mark_code[1]
               && in_bounds(int'(mark_x), int'(mark_y), BOARD_W, BOARD_H);
    start_go = phase_q == PLACE && start_req && ship_count == MAX_CNT;
    h_data   = place_go ? SHIP : host_rm == SHIP ? HIT : MISS;
    clr_en   = phase_q == CLEAR;
    phase_d  = phase_q == PLACE  ? (start_go ? BATTLE : PLACE)
             : phase_q == BATTLE ? (hits_taken == MAX_CNT ? OVER : BATTLE)
             : phase_q == OVER   ? (new_game ? CLEAR : OVER)
             :                     (clr_row == LAST_ROW ? PLACE : CLEAR);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PLACE;
      ship_count  <= '0;
      hits_taken  <= '0;
      clr_row     <= '0;
      place_done  <= 1'b0;
      place_ok    <= 1'b0;
      shot_done   <= 1'b0;
      shot_result <= RES_NONE;
    end else begin
      phase_q     <= phase_d;
      place_done  <= place_req;
      place_ok    <= place_go;
      shot_done   <= shot_req;
      shot_result <= !shot_go ? RES_NONE : host_rm == SHIP ? RES_HIT : RES_MISS;
      if (phase_q == OVER && new_game) begin
        ship_count <= '0;
        hits_taken <= '0;
        clr_row    <= '0;
      end else begin
        if (place_go) ship_count <= ship_count + 1'b1;
        if (shot_go && host_rm == SHIP) hits_taken <= hits_taken + 1'b1;
        if (clr_en) clr_row <= clr_row + 1'b1;
      end
    end
  end
  board_bank #(.W(BOARD_W), .H(BOARD_H), .CW(CW)) u_host (
    .clk(clk), .rst(rst),
    .wr_en(place_go | shot_go), .wr_x(h_x), .wr_y(h_y), .wr_data(h_data),
    .rm_x(h_x), .rm_y(h_y), .rm_code(host_rm),
    .rd_x(rd_host_x), .rd_y(rd_host_y), .rd_code(host_rd),
    .clr_en(clr_en), .clr_row(clr_row)
  );
  board_bank #(.W(BOARD_W), .H(BOARD_H), .CW(CW)) u_guest (
    .clk(clk), .rst(rst),
    .wr_en(mark_go), .wr_x(mark_x), .wr_y(mark_y), .wr_data(cell_t'(mark_code)),
    .rm_x(mark_x), .rm_y(mark_y), .rm_code(guest_rm),
    .rd_x(rd_guest_x), .rd_y(rd_guest_y), .rd_code(guest_rd),
    .clr_en(clr_en), .clr_row(clr_row)
  );
  assign host_code  = host_rd;
  assign guest_code = guest_rd;
  assign phase      = phase_q;
  assign fleet_sunk = hits_taken == MAX_CNT;
endmodule

// File: tb/tb_battle_board.sv
// tb_battle_board: directed vectors for battle_board with MAX_SHIPS=2 on a 10x10 board
module tb_battle_board;
  logic clk = 0, rst = 1;
  logic place_req = 0, start_req = 0, shot_req = 0, mark_req = 0, new_game = 0;
  logic [3:0] place_x = 0, place_y = 0, shot_x = 0, shot_y = 0, mark_x = 0, mark_y = 0;
  logic [3:0] rd_host_x = 0, rd_host_y = 0, rd_guest_x = 0, rd_guest_y = 0;
  logic [1:0] mark_code = 0;
  logic place_done, place_ok, shot_done, fleet_sunk;
  logic [1:0] shot_result, host_code, guest_code, phase;
  logic [1:0] ship_count, hits_taken;
  int vectors = 0, miscompares = 0;
  int n;
  battle_board #(.BOARD_W(10), .BOARD_H(10), .MAX_SHIPS(2), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .place_req(place_req), .place_x(place_x), .place_y(place_y),
    .place_done(place_done), .place_ok(place_ok), .start_req(start_req),
    .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
    .shot_done(shot_done), .shot_result(shot_result),
    .mark_req(mark_req), .mark_x(mark_x), .mark_y(mark_y), .mark_code(mark_code),
    .new_game(new_game),
    .rd_host_x(rd_host_x), .rd_host_y(rd_host_y), .rd_guest_x(rd_guest_x), .rd_guest_y(rd_guest_y),
    .host_code(host_code), .guest_code(guest_code),
    .ship_count(ship_count), .hits_taken(hits_taken), .phase(phase), .fleet_sunk(fleet_sunk)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic place(input logic [3:0] x, input logic [3:0] y);
    place_req = 1; place_x = x; place_y = y;
    tick;
    place_req = 0;
  endtask
  task automatic shoot(input logic [3:0] x, input logic [3:0] y);
    shot_req = 1; shot_x = x; shot_y = y;
    tick;
    shot_req = 0;
  endtask
  task automatic mark(input logic [3:0] x, input logic [3:0] y, input logic [1:0] c);
    mark_req = 1; mark_x = x; mark_y = y; mark_code = c;
    tick;
    mark_req = 0;
  endtask
  task automatic start;
    start_req = 1;
    tick;
    start_req = 0;
  endtask
  initial begin
    tick; tick;
    rst = 0;
    check("rst_phase", phase, 0);
    check("rst_ships", ship_count, 0);
    check("rst_hits", hits_taken, 0);
    check("rst_sunk", fleet_sunk, 0);
    check("rst_pdone", place_done, 0);
    check("rst_sdone", shot_done, 0);
    check("rst_host", host_code, 0);
    place(0, 0);
    check("place1_done", place_done, 1);
    check("place1_ok", place_ok, 1);
    check("place1_cnt", ship_count, 1);
    check("place1_rd_old", host_code, 0);
    tick;
    check("place1_rd", host_code, 1);
    check("done_pulse", place_done, 0);
    place(0, 0);
    check("place_dup_ok", place_ok, 0);
    check("place_dup_cnt", ship_count, 1);
    start;
    check("start_early", phase, 0);
    place(10, 0);
    check("place_oob_ok", place_ok, 0);
    place(5, 5);
    check("place2_ok", place_ok, 1);
    check("place2_cnt", ship_count, 2);
    place(1, 1);
    check("place_full_ok", place_ok, 0);
    check("place_full_cnt", ship_count, 2);
    shoot(0, 0);
    check("shot_place_done", shot_done, 1);
    check("shot_place_res", shot_result, 0);
    start;
    check("start_ok", phase, 1);
    shoot(0, 0);
    check("shot_hit_res", shot_result, 2'b10);
    check("shot_hit_cnt", hits_taken, 1);
    tick;
    check("shot_hit_cell", host_code, 2'b10);
    shoot(0, 0);
    check("shot_rep_res", shot_result, 0);
    check("shot_rep_cnt", hits_taken, 1);
    rd_host_x = 2; rd_host_y = 3;
    shoot(2, 3);
    check("shot_miss_res", shot_result, 2'b11);
    tick;
    check("shot_miss_cell", host_code, 2'b11);
    shoot(10, 0);
    check("shot_oob_res", shot_result, 0);
    rd_guest_x = 1; rd_guest_y = 1;
    mark(1, 1, 2'b01);
    tick;
    check("mark_bad_code", guest_code, 0);
    rd_guest_x = 3; rd_guest_y = 4;
    mark(3, 4, 2'b11);
    tick;
    check("mark_miss", guest_code, 2'b11);
    mark_req = 1; mark_x = 3; mark_y = 4; mark_code = 2'b10;
    shoot(5, 5);
    mark_req = 0;
    check("sink_res", shot_result, 2'b10);
    check("sink_hits", hits_taken, 2);
    check("sink_flag", fleet_sunk, 1);
    check("sink_phase_same", phase, 1);
    tick;
    check("over_phase", phase, 2);
    check("mark_overwrite", guest_code, 2'b10);
    rd_host_x = 2; rd_host_y = 2;
    shoot(2, 2);
    check("over_shot_done", shot_done, 1);
    check("over_shot_res", shot_result, 0);
    tick;
    check("over_no_write", host_code, 0);
    place(7, 7);
    check("over_place_ok", place_ok, 0);
    check("over_place_cnt", ship_count, 2);
    rd_host_x = 0; rd_host_y = 0;
    new_game = 1;
    tick;
    new_game = 0;
    check("clear_phase", phase, 3);
    check("clear_ships", ship_count, 0);
    check("clear_hits", hits_taken, 0);
    n = 1;
    while (phase == 2'd3 && n < 30) begin
      tick;
      if (phase == 2'd3) n++;
    end
    check("clear_len", n, 10);
    check("clear_end_phase", phase, 0);
    tick;
    check("clear_host", host_code, 0);
    check("clear_guest", guest_code, 0);
    place(0, 0);
    place(1, 0);
    start;
    shoot(0, 0);
    shoot(1, 0);
    tick;
    check("over2_phase", phase, 2);
    new_game = 1;
    tick;
    new_game = 0;
    tick; tick;
    check("mid_sweep", phase, 3);
    rst = 1;
    tick;
    rst = 0;
    check("rst_sweep_phase", phase, 0);
    check("rst_sweep_cnt", ship_count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
